// File: rtl/codificare.sv
// codificare: iterative IDEA encryption core (8 rounds + output transform).
// The 52 subkeys come combinationally from the latched key register.
// Optional build macro CODIFICARE_UNROLL2_EN: two cascaded rounds per clock.
// With it, ROUND takes 4 edges instead of 8. Results are the same either way.
module codificare (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] K,
    input  logic [63:0]  X,
    output logic [63:0]  X_OUT,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t        state_reg;
    logic [63:0]   x_reg;
    logic [127:0]  key_reg;
    logic [2:0]    round_cnt_reg;
    logic [63:0]   x_out_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [15:0]   z         [0:51];
    logic [95:0]   round_key [0:7];
    logic [63:0]   round_next;
    logic [63:0]   out_transform;

    // Multiplication mod 2^16+1, where the word 0x0000 stands for 2^16.
    // The low-minus-high fold avoids a real modulo on the 32-bit product.
    function automatic logic [15:0] mul16(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        logic [15:0] lo, hi;
        if (a == 16'd0) begin
            mul16 = 16'd1 - b;
        end else if (b == 16'd0) begin
            mul16 = 16'd1 - a;
        end else begin
            p     = {16'd0, a} * {16'd0, b};
            lo    = p[15:0];
            hi    = p[31:16];
            mul16 = lo - hi + {15'd0, (lo < hi)};
        end
    endfunction

    // One full IDEA round; the two middle words come out swapped.
    function automatic logic [63:0] idea_round(input logic [63:0] x, input logic [95:0] k);
        logic [15:0] a, b, c, d, e, f, g, h, i, j;
        a = mul16(x[63:48], k[95:80]);
        b = x[47:32] + k[79:64];
        c = x[31:16] + k[63:48];
        d = mul16(x[15:0], k[47:32]);
        e = a ^ c;
        f = b ^ d;
        g = mul16(e, k[31:16]);
        h = f + g;
        i = mul16(h, k[15:0]);
        j = g + i;
        idea_round = {a ^ i, c ^ i, b ^ j, d ^ j};
    endfunction

    // Subkey n is the 16-bit window starting (25*(n/8) + 16*(n%8)) mod 128
    // bits below the key MSB, wrapping around; this is the rotate-by-25 schedule.
    genvar gi;
    generate
        for (gi = 0; gi < 52; gi++) begin : g_subkey
            localparam int BASE = (25 * (gi / 8) + 16 * (gi % 8)) % 128;
            if (BASE <= 112) begin : g_flat
                assign z[gi] = key_reg[127-BASE -: 16];
            end else begin : g_wrap
                assign z[gi] = {key_reg[127-BASE:0], key_reg[127 -: (BASE-112)]};
            end
        end
        for (gi = 0; gi < 8; gi++) begin : g_round_key
            assign round_key[gi] = {z[6*gi],   z[6*gi+1], z[6*gi+2],
                                    z[6*gi+3], z[6*gi+4], z[6*gi+5]};
        end
    endgenerate

`ifdef CODIFICARE_UNROLL2_EN
    localparam logic [2:0] ROUND_STEP = 3'd2;
    localparam logic [2:0] ROUND_LAST = 3'd6;
    logic [63:0] round_mid;
    assign round_mid  = idea_round(x_reg, round_key[round_cnt_reg]);
    assign round_next = idea_round(round_mid, round_key[round_cnt_reg + 3'd1]);
`else
    localparam logic [2:0] ROUND_STEP = 3'd1;
    localparam logic [2:0] ROUND_LAST = 3'd7;
    assign round_next = idea_round(x_reg, round_key[round_cnt_reg]);
`endif

    // Output transform reverses the final swap (X3 feeds the second word).
    assign out_transform = {mul16(x_reg[63:48], z[48]),
                            x_reg[31:16] + z[49],
                            x_reg[47:32] + z[50],
                            mul16(x_reg[15:0], z[51])};

    // Control FSM: latch inputs, iterate rounds, register the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            key_reg       <= '0;
            round_cnt_reg <= '0;
            x_out_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg         <= X;
                        key_reg       <= K;
                        round_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ROUND;
                    end
                end
                ROUND: begin
                    x_reg         <= round_next;
                    round_cnt_reg <= round_cnt_reg + ROUND_STEP;
                    if (round_cnt_reg == ROUND_LAST) begin
                        state_reg <= FINAL;
                    end
                end
                FINAL: begin
                    x_out_reg     <= out_transform;
                    done_reg      <= 1'b1;
                    busy_reg      <= 1'b0;
                    round_cnt_reg <= '0;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign X_OUT = x_out_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_codificare.sv
// tb_codificare: randomized and directed checks of the IDEA core against a
// behavioural model built directly from the cipher's arithmetic definitions.
module tb_codificare;

`ifdef CODIFICARE_UNROLL2_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 9;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] K;
    logic [63:0]  X;
    logic [63:0]  X_OUT;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] K1 = 128'h006400C8012C019001F4025802BC0320;
    localparam logic [63:0]  X1 = 64'h05320A6414C819FA;
    localparam logic [63:0]  C1 = 64'h65BE87E7A2538AED;
    localparam logic [127:0] K2 = 128'h00010002000300040005000600070008;
    localparam logic [63:0]  X2 = 64'h0000000100020003;
    localparam logic [63:0]  C2 = 64'h11FBED2B01986DE5;
    localparam logic [63:0]  C3 = 64'h0001000100000000;

    codificare dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .K     (K),
        .X     (X),
        .X_OUT (X_OUT),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] mulm(input logic [15:0] a, input logic [15:0] b);
        longint aa, bb;
        aa = (a == 16'd0) ? 65536 : longint'(a);
        bb = (b == 16'd0) ? 65536 : longint'(b);
        return 16'((aa * bb) % 65537);
    endfunction

    function automatic logic [63:0] model_idea(input logic [127:0] k, input logic [63:0] x);
        logic [15:0]  zk [52];
        logic [127:0] kk;
        logic [15:0]  w [4];
        logic [15:0]  a, b, c, d, e, f, g, h, i, j;
        kk = k;
        for (int n = 0; n < 52; n++) begin
            if (n > 0 && n % 8 == 0) kk = {kk[102:0], kk[127:103]};
            zk[n] = 16'(kk >> (112 - 16 * (n % 8)));
        end
        w[0] = x[63:48]; w[1] = x[47:32]; w[2] = x[31:16]; w[3] = x[15:0];
        for (int r = 0; r < 8; r++) begin
            a = mulm(w[0], zk[6*r]);
            b = 16'(w[1] + zk[6*r+1]);
            c = 16'(w[2] + zk[6*r+2]);
            d = mulm(w[3], zk[6*r+3]);
            e = a ^ c;
            f = b ^ d;
            g = mulm(e, zk[6*r+4]);
            h = 16'(f + g);
            i = mulm(h, zk[6*r+5]);
            j = 16'(g + i);
            w[0] = a ^ i; w[1] = c ^ i; w[2] = b ^ j; w[3] = d ^ j;
        end
        return {mulm(w[0], zk[48]), 16'(w[2] + zk[49]), 16'(w[1] + zk[50]), mulm(w[3], zk[51])};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Caller is at a falling edge; start is held for one rising edge, then
    // K/X are scrambled to show the core latched them.
    task automatic launch(input logic [127:0] k, input logic [63:0] x);
        K = k; X = x; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        K = {$urandom, $urandom, $urandom, $urandom};
        X = {$urandom, $urandom};
    endtask

    // Waits for done (bounded); busy must stay high until then and drop with done.
    task automatic wait_done(output logic [63:0] res, output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_hold: cycle %0d busy=%b required 1", n, busy);
            end
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within 40 cycles");
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done: busy=%b required 0", busy);
            end
        end
        res = X_OUT;
    endtask

    task automatic check_result(input string name, input logic [63:0] got, input logic [63:0] exp,
                                input int lat);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_xout: got %h required %h", name, got, exp);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, LAT);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; K = '0; X = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (X_OUT !== 64'd0) begin errors++; $display("FAIL reset_xout: got %h required 0", X_OUT); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: X_OUT=%h busy=%b done=%b", X_OUT, busy, done);
    endtask

    task automatic test_known_vectors();
        logic [127:0] kv [3];
        logic [63:0]  xv [3];
        logic [63:0]  cv [3];
        logic [63:0]  res;
        int           lat;
        kv[0] = K1;    xv[0] = X1;    cv[0] = C1;
        kv[1] = K2;    xv[1] = X2;    cv[1] = C2;
        kv[2] = '0;    xv[2] = '0;    cv[2] = C3;
        for (int v = 0; v < 3; v++) begin
            launch(kv[v], xv[v]);
            wait_done(res, lat);
            $display("known[%0d]: K=%h X=%h -> X_OUT=%h lat=%0d", v, kv[v], xv[v], res, lat);
            check_result("known", res, cv[v], lat);
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b required 0", done); end
            checks++;
            if (X_OUT !== cv[v]) begin errors++; $display("FAIL xout_hold: got %h required %h", X_OUT, cv[v]); end
        end
    endtask

    task automatic test_start_ignored();
        int n_done = 0;
        int first  = -1;
        launch(K1, X1);
        for (int n = 1; n <= 30; n++) begin
            if (n == 3) begin K = K2; X = X2; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (first < 0) first = n;
            end
        end
        start = 1'b0;
        $display("start_ignored: dones=%0d first=%0d X_OUT=%h", n_done, first, X_OUT);
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL ignored_done_count: got %0d required 1", n_done); end
        check_result("ignored", X_OUT, C1, first);
    endtask

    task automatic test_abort();
        int n_done = 0;
        logic [63:0] res;
        int lat;
        launch(K1, X1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (X_OUT !== 64'd0) begin errors++; $display("FAIL abort_xout: got %h required 0", X_OUT); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d dones required 0", n_done); end
        launch(K2, X2);
        wait_done(res, lat);
        $display("abort: spurious dones=%0d, fresh X_OUT=%h lat=%0d", n_done, res, lat);
        check_result("after_abort", res, C2, lat);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int lat;
        launch(K1, X1);
        wait_done(res, lat);
        check_result("b2b_first", res, C1, lat);
        launch(K2, X2);
        wait_done(res, lat);
        $display("back_to_back: second X_OUT=%h lat=%0d", res, lat);
        check_result("b2b_second", res, C2, lat);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [127:0] k;
        logic [63:0]  x, res, exp;
        int lat;
        for (int t = 0; t < 10; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            x = {$urandom, $urandom};
            if (t == 0) x[63:48] = 16'd0;
            if (t == 1) k[127:112] = 16'd0;
            exp = model_idea(k, x);
            launch(k, x);
            wait_done(res, lat);
            $display("random[%0d]: K=%h X=%h -> X_OUT=%h model=%h lat=%0d", t, k, x, res, exp, lat);
            check_result("random", res, exp, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
